// File: rtl/mips_cpu_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_pc_unit_if
// Brief    : Decode-in / fetch-out bundle between the control path and the PC unit.
// Revision : 1.0
// ============================================================================
interface mips_cpu_pc_unit_if;
  logic        stall;
  logic        branch;
  logic        branch_taken;
  logic        jump;
  logic        jump_reg;
  logic [25:0] instr_index;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        in_delay_slot;
  logic        active;

  modport master (
    output stall, branch, branch_taken, jump, jump_reg, instr_index, rs_data,
    input  pc, link_addr, in_delay_slot, active
  );

  modport slave (
    input  stall, branch, branch_taken, jump, jump_reg, instr_index, rs_data,
    output pc, link_addr, in_delay_slot, active
  );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_pc_unit
// Brief    : Program counter / next-PC sequencer with one branch-delay slot.
// Revision : 1.0
// ============================================================================
module mips_cpu_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
  input  wire logic             clk,
  input  wire logic             reset,
  mips_cpu_pc_unit_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DELAY = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_pending;
  logic [31:0] w_pending_nxt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_offset;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_jr_target;
  logic        w_redirect;
  logic [31:0] w_target;

  always_comb begin
    w_pc_plus4  = r_pc + 32'd4;
    w_br_offset = {{14{bus.instr_index[15]}}, bus.instr_index[15:0], 2'b00};
    w_br_target = w_pc_plus4 + w_br_offset;
    w_j_target  = {w_pc_plus4[31:28], bus.instr_index, 2'b00};
    w_jr_target = {bus.rs_data[31:2], 2'b00};
  end

  // Target priority: jump_reg over jump over a taken branch.
  always_comb begin
    w_redirect = bus.jump_reg | bus.jump | (bus.branch & bus.branch_taken);
    if (bus.jump_reg)
      w_target = w_jr_target;
    else if (bus.jump)
      w_target = w_j_target;
    else
      w_target = w_br_target;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pending_nxt = r_pending;
    if (!bus.stall) begin
      case (r_state)
        ST_RUN: begin
          w_pc_nxt = w_pc_plus4;
          if (w_redirect) begin
            w_pending_nxt = w_target;
            w_state_nxt   = ST_DELAY;
          end
        end
        // Decode inputs of the delay-slot instruction are deliberately ignored.
        ST_DELAY: begin
          if (r_pending == HALT_ADDR) begin
            w_pc_nxt    = HALT_ADDR;
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_nxt    = r_pending;
            w_state_nxt = ST_RUN;
          end
        end
        ST_HALT: begin
          w_pc_nxt = HALT_ADDR;
        end
        default: begin
          w_pc_nxt    = RESET_VECTOR;
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_VECTOR;
      r_pending <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign bus.pc            = r_pc;
  assign bus.link_addr     = r_pc + 32'd8;
  assign bus.in_delay_slot = (r_state == ST_DELAY);
  assign bus.active        = (r_state != ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_pc_unit
// Brief    : Directed vector bench for the PC sequencer.
// Revision : 1.0
// ============================================================================
module tb_mips_cpu_pc_unit;

  typedef struct {
    logic        stall;
    logic        br;
    logic        tk;
    logic        j;
    logic        jr;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] epc;
    logic        eds;
    logic        eact;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t tbl[$];

  mips_cpu_pc_unit_if bus();

  mips_cpu_pc_unit #(
    .RESET_VECTOR(32'hBFC0_0000),
    .HALT_ADDR   (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic stall, input logic br, input logic tk,
                              input logic j, input logic jr, input logic [25:0] idx,
                              input logic [31:0] rs, input logic [31:0] epc,
                              input logic eds, input logic eact);
    vec_t v;
    v.stall = stall; v.br = br; v.tk = tk; v.j = j; v.jr = jr;
    v.idx = idx; v.rs = rs; v.epc = epc; v.eds = eds; v.eact = eact;
    return v;
  endfunction

  function automatic vec_t nop(input logic [31:0] epc, input logic eds, input logic eact);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0, 32'd0, epc, eds, eact);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] epc,
                           input logic eds, input logic eact);
    chk({tag, " pc"}, bus.pc, epc);
    chk({tag, " link"}, bus.link_addr, epc + 32'd8);
    chk({tag, " ds"}, {31'd0, bus.in_delay_slot}, {31'd0, eds});
    chk({tag, " active"}, {31'd0, bus.active}, {31'd0, eact});
  endtask

  task automatic drive(input vec_t v);
    bus.stall        = v.stall;
    bus.branch       = v.br;
    bus.branch_taken = v.tk;
    bus.jump         = v.j;
    bus.jump_reg     = v.jr;
    bus.instr_index  = v.idx;
    bus.rs_data      = v.rs;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Main walk from reset; each record holds inputs for the current pc and the post-edge result.
    for (int i = 1; i <= 4; i++) tbl.push_back(nop(32'hBFC0_0000 + 32'(4*i), 1'b0, 1'b1));
    tbl.push_back(mk(0,1,1,0,0, 26'h000FFFC, 32'd0, 32'hBFC0_0014, 1, 1));       // BEQ taken
    tbl.push_back(nop(32'hBFC0_0004, 1'b0, 1'b1));
    for (int i = 2; i <= 8; i++) tbl.push_back(nop(32'hBFC0_0000 + 32'(4*i), 1'b0, 1'b1));
    tbl.push_back(mk(0,0,0,1,0, 26'h0000100, 32'd0, 32'hBFC0_0024, 1, 1));       // J
    tbl.push_back(nop(32'hB000_0400, 1'b0, 1'b1));
    tbl.push_back(mk(0,0,0,1,0, 26'h0000010, 32'd0, 32'hB000_0404, 1, 1));       // JAL
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,1,1,1,1, 26'h3FFFFFF, 32'h1234_5678, 32'hB000_0404, 1, 1));
    tbl.push_back(nop(32'hB000_0040, 1'b0, 1'b1));
    tbl.push_back(mk(0,1,1,1,1, 26'h3FFFFFF, 32'hBFC0_0031, 32'hB000_0044, 1, 1)); // JR wins
    tbl.push_back(nop(32'hBFC0_0030, 1'b0, 1'b1));
    tbl.push_back(mk(0,0,0,1,0, 26'h3F00040, 32'd0, 32'hBFC0_0034, 1, 1));       // J to BFC00100
    tbl.push_back(mk(0,1,1,0,0, 26'h0000072, 32'd0, 32'hBFC0_0100, 0, 1));       // slot branch
    tbl.push_back(nop(32'hBFC0_0104, 1'b0, 1'b1));
    tbl.push_back(mk(0,0,0,0,1, 26'd0, 32'hFFFF_FFFC, 32'hBFC0_0108, 1, 1));
    tbl.push_back(nop(32'hFFFF_FFFC, 1'b0, 1'b1));
    tbl.push_back(nop(32'h0000_0000, 1'b0, 1'b1));                              // wrap, no halt
    tbl.push_back(nop(32'h0000_0004, 1'b0, 1'b1));
    tbl.push_back(mk(0,1,0,0,0, 26'h0000010, 32'd0, 32'h0000_0008, 0, 1));       // not taken
    tbl.push_back(mk(0,0,0,0,1, 26'd0, 32'h0000_0000, 32'h0000_000C, 1, 1));     // JR 0
    tbl.push_back(nop(32'h0000_0000, 1'b0, 1'b0));                              // halt
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,1,1,1,1, 26'h0000100, 32'h0000_0040, 32'h0000_0000, 0, 0));

    drive(nop(32'd0, 1'b0, 1'b0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_state("reset", 32'hBFC0_0000, 1'b0, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), tbl[i].epc, tbl[i].eds, tbl[i].eact);
    end

    // Reset out of HALT, then async reset landing inside a delay slot.
    drive(nop(32'd0, 1'b0, 1'b0));
    #3;
    reset = 1'b1;
    #1;
    chk_state("halt reset", 32'hBFC0_0000, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(mk(0,0,0,1,0, 26'h0000010, 32'd0, 32'd0, 0, 0));
    @(posedge clk);
    #1;
    chk_state("pre-reset slot", 32'hBFC0_0004, 1'b1, 1'b1);
    drive(nop(32'd0, 1'b0, 1'b0));
    #3;
    reset = 1'b1;
    #1;
    chk_state("async reset", 32'hBFC0_0000, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_state("post reset 1", 32'hBFC0_0004, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_state("post reset 2", 32'hBFC0_0008, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_cpu_pc_unit.md
# mips_cpu_pc_unit

Program-counter and next-PC sequencer for the MIPS core, sitting directly downstream of `mips_cpu_control`. It consumes the decoded Branch/Jump class signals, an external branch-condition result and the current instruction fields. It computes branch, jump and jump-register targets, enforces the MIPS single branch-delay slot, and drives the instruction fetch address. It also produces the link address for JAL/JALR/BxxAL and the CPU `active` flag, which drops when execution returns to address 0.

## Interface

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC value loaded on reset.
- HALT_ADDR, 32'h0000_0000, jump target that terminates execution.

Ports:
- clk  input  1  core clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  freeze request (memory wait); holds all state when 1.
- branch  input  1  Branch from control (REGIMM, BEQ, BNE, BLEZ, BGTZ).
- branch_taken  input  1  condition result from the comparator; qualified by `branch`.
- jump  input  1  Jump from control (J, JAL).
- jump_reg  input  1  JR/JALR decoded from funct.
- instr_index  input  26  instr[25:0].
- rs_data  input  32  register rs value, used as the JR/JALR target.
- pc  output  32  current fetch address (registered).
- link_addr  output  32  pc + 8, the link value (combinational from `pc`).
- in_delay_slot  output  1  the instruction at `pc` is a delay slot.
- active  output  1  1 while executing; 0 once halted.

## Operation

- Immediate field: `imm16 = instr_index[15:0]`. Branch offset is `sign_extend(imm16) << 2`, 32-bit wrap-around add.
- Target computation at branch/jump address P:
  - Branch: P + 4 + offset.
  - J/JAL: {(P+4)[31:28], instr_index, 2'b00}.
  - JR/JALR: {rs_data[31:2], 2'b00}. Low bits are silently cleared.
- A redirect is requested when `jump_reg`, or else `jump`, or else (`branch & branch_taken`) is set. Priority is jump_reg > jump > branch. A not-taken branch is a normal sequential step.
- States:
  - RUN:
    - No redirect: pc <= pc+4.
    - Redirect: latch target into `pending`, pc <= pc+4, go to DELAY.
  - DELAY: the instruction at `pc` is the delay slot.
    - If pending == HALT_ADDR: pc <= HALT_ADDR, go to HALT.
    - Otherwise: pc <= pending, go to RUN.
    - Any branch/jump presented in the delay slot is ignored. No new pending target is latched, and the delay-slot instruction's own redirect is dropped.
  - HALT: pc holds HALT_ADDR and all inputs are ignored. Only reset exits.
- `in_delay_slot` = (state == DELAY).
- `active` = (state != HALT).
- stall = 1: pc, pending and state all hold, regardless of other inputs.
- Reset (asynchronous, any state, mid-stall or mid-delay-slot):
  - pc = RESET_VECTOR, pending = 0, state = RUN.
  - active = 1, in_delay_slot = 0.
  - link_addr = RESET_VECTOR + 8.
- Sequential wrap-around: pc = 32'hFFFF_FFFC steps to 32'h0000_0000 with no halt. Halt only occurs through a redirect to HALT_ADDR.

## Timing

- All state updates happen on the rising edge of `clk` when stall = 0. The pc value is visible on the same edge.
- Redirect latency is 2 edges: edge 1 moves to the delay slot (P+4), edge 2 moves to the target.
- Decode inputs are sampled on the edge that advances from P. They must be stable while `pc` = P and stall = 0.
- `link_addr` and `in_delay_slot` are valid in the same cycle as `pc`.
- `active` falls on the edge where pc becomes HALT_ADDR.
- Stall is level-sensitive and has no cycle loss: the first edge with stall = 0 performs the step pending for the current pc.

## Test plan

- Reset then 3 free edges:
  - pc = BFC00000 → BFC00004 → BFC00008 → BFC0000C.
  - active = 1 throughout; link_addr = BFC00008 at reset.
- BEQ taken at pc = BFC00010, imm16 = 16'hFFFC:
  - next pc = BFC00014 with in_delay_slot = 1.
  - then pc = BFC00004 (BFC00014 − 16).
- J at pc = BFC00020, instr_index = 26'h0000100:
  - pc goes BFC00024 → B0000400.
- JR with rs_data = 0 at pc = BFC00030:
  - pc goes BFC00034 → 00000000, and active falls on that edge.
  - pc stays at 0 for 5 further edges with jump/branch asserted.
- Stall held 4 cycles during DELAY after a JAL to 26'h10:
  - pc, in_delay_slot and link_addr are frozen for 4 cycles.
  - after release, pc = B0000040 in one edge.
- Branch asserted in the delay slot (pending = BFC00100, slot branch target BFC00200):
  - pc = BFC00100, and the slot branch is ignored.
- Async reset asserted mid-DELAY, off-edge:
  - pc = BFC00000 and in_delay_slot = 0 immediately.
  - the pending target is not applied after reset releases.
